// File: rtl/console_stdout_tx.sv
// Console transmitter for the processor's stdout port: queues the low byte of each
// stdout write in a small FIFO and shifts it out as 8N1 UART frames, LSB first.
module console_stdout_tx #(
  parameter int unsigned CLKS_POR_BIT = 16,
  parameter int unsigned PROF_FIFO    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] stdout,
  input  logic        stdout_esc,
  output logic        tx,
  output logic        ocupado,
  output logic        cheia,
  output logic [7:0]  descartados
);

  localparam int unsigned BaudW = (CLKS_POR_BIT > 1) ? $clog2(CLKS_POR_BIT) : 1;
  localparam int unsigned PtrW  = (PROF_FIFO > 1) ? $clog2(PROF_FIFO) : 1;
  localparam int unsigned CntW  = PtrW + 1;
  localparam logic [BaudW-1:0] BaudMax = BaudW'(CLKS_POR_BIT - 1);
  localparam logic [CntW-1:0]  CntFull = CntW'(PROF_FIFO);

  typedef enum logic [1:0] {StOcioso, StInicio, StDados, StParada} estado_t;

  estado_t           r_estado, w_estado_d;
  logic [BaudW-1:0]  r_baud, w_baud_d;
  logic [2:0]        r_idx, w_idx_d;
  logic [7:0]        r_shift, w_shift_d;
  logic              r_tx, w_tx_d;
  logic [7:0]        r_desc, w_desc_d;

  logic [7:0]        r_mem [PROF_FIFO];
  logic [PtrW-1:0]   r_rd, r_wr;
  logic [CntW-1:0]   r_count, w_count_d;

  logic w_vazia, w_cheia, w_push, w_pop, w_fim_bit;
  logic w_unused_stdout;

  assign w_unused_stdout = ^stdout[31:8];

  // Fullness is judged on the pre-edge count, so a full FIFO drops even when popping.
  assign w_vazia   = (r_count == '0);
  assign w_cheia   = (r_count == CntFull);
  assign w_push    = stdout_esc && !w_cheia;
  assign w_fim_bit = (r_baud == BaudMax);

  always_comb begin
    w_estado_d = r_estado;
    w_baud_d   = r_baud + 1'b1;
    w_idx_d    = r_idx;
    w_shift_d  = r_shift;
    w_pop      = 1'b0;
    unique case (r_estado)
      StOcioso: begin
        w_baud_d = '0;
        if (!w_vazia) begin
          w_pop      = 1'b1;
          w_shift_d  = r_mem[r_rd];
          w_estado_d = StInicio;
        end
      end
      StInicio: begin
        if (w_fim_bit) begin
          w_baud_d   = '0;
          w_idx_d    = 3'd0;
          w_estado_d = StDados;
        end
      end
      StDados: begin
        if (w_fim_bit) begin
          w_baud_d  = '0;
          w_shift_d = {1'b0, r_shift[7:1]};
          w_idx_d   = r_idx + 3'd1;
          if (r_idx == 3'd7) begin
            w_estado_d = StParada;
          end
        end
      end
      StParada: begin
        if (w_fim_bit) begin
          w_baud_d = '0;
          if (!w_vazia) begin
            w_pop      = 1'b1;
            w_shift_d  = r_mem[r_rd];
            w_estado_d = StInicio;
          end else begin
            w_estado_d = StOcioso;
          end
        end
      end
      default: w_estado_d = StOcioso;
    endcase

    // tx is computed from next state so the registered line switches on the same edge.
    unique case (w_estado_d)
      StInicio: w_tx_d = 1'b0;
      StDados:  w_tx_d = w_shift_d[0];
      default:  w_tx_d = 1'b1;
    endcase
  end

  always_comb begin
    w_count_d = r_count;
    unique case ({w_push, w_pop})
      2'b10:   w_count_d = r_count + CntW'(1);
      2'b01:   w_count_d = r_count - CntW'(1);
      default: w_count_d = r_count;
    endcase
  end

  always_comb begin
    w_desc_d = r_desc;
    if (stdout_esc && w_cheia && (r_desc != 8'hFF)) begin
      w_desc_d = r_desc + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_estado <= StOcioso;
      r_baud   <= '0;
      r_idx    <= '0;
      r_shift  <= '0;
      r_tx     <= 1'b1;
      r_desc   <= '0;
      r_rd     <= '0;
      r_wr     <= '0;
      r_count  <= '0;
    end else begin
      r_estado <= w_estado_d;
      r_baud   <= w_baud_d;
      r_idx    <= w_idx_d;
      r_shift  <= w_shift_d;
      r_tx     <= w_tx_d;
      r_desc   <= w_desc_d;
      r_count  <= w_count_d;
      if (w_push) begin
        r_wr <= r_wr + 1'b1;
      end
      if (w_pop) begin
        r_rd <= r_rd + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr] <= stdout[7:0];
    end
  end

  assign tx          = r_tx;
  assign ocupado     = (r_estado != StOcioso) || !w_vazia;
  assign cheia       = w_cheia;
  assign descartados = r_desc;

endmodule

// File: tb/tb_console_stdout_tx.sv
// Directed bench for console_stdout_tx: frame shape and latency, back-to-back frames,
// overflow/saturation of the drop counter and reset mid-frame.
module tb_console_stdout_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] stdout = '0;
  logic        stdout_esc = 1'b0;
  logic        tx, ocupado, cheia;
  logic [7:0]  descartados;

  int n_checks = 0;
  int n_errors = 0;

  console_stdout_tx #(
    .CLKS_POR_BIT(4),
    .PROF_FIFO   (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .stdout     (stdout),
    .stdout_esc (stdout_esc),
    .tx         (tx),
    .ocupado    (ocupado),
    .cheia      (cheia),
    .descartados(descartados)
  );

  always #5 clk = ~clk;

  // Independent UART receiver: samples mid-bit on the falling clock edge.
  logic [7:0] rx_q[$];
  logic       rx_busy = 1'b0;
  int         rx_cnt = 0;
  logic [7:0] rx_sh = '0;
  int         rx_bad = 0;

  always @(negedge clk) begin
    if (rst) begin
      rx_busy <= 1'b0;
      rx_cnt  <= 0;
    end else if (!rx_busy) begin
      if (tx == 1'b0) begin
        rx_busy <= 1'b1;
        rx_cnt  <= 1;
      end
    end else begin
      rx_cnt <= rx_cnt + 1;
      if (rx_cnt == 2 && tx != 1'b0) rx_bad <= rx_bad + 1;
      if ((rx_cnt % 4) == 2 && rx_cnt >= 6 && rx_cnt <= 34) rx_sh[rx_cnt / 4 - 1] <= tx;
      if (rx_cnt == 38) begin
        if (tx != 1'b1) rx_bad <= rx_bad + 1;
        rx_q.push_back(rx_sh);
      end
      if (rx_cnt == 39) rx_busy <= 1'b0;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts on the first cycle of the start bit; records 40 cycles of tx and ocupado.
  task automatic capture(input logic [7:0] b, input string tag);
    logic [39:0] got_tx, exp_tx, got_oc;
    logic [9:0]  fr;
    fr = {1'b1, b, 1'b0};
    for (int c = 0; c < 40; c++) begin
      got_tx[c] = tx;
      got_oc[c] = ocupado;
      exp_tx[c] = fr[c / 4];
      tick();
      stdout_esc = 1'b0;
    end
    check({tag, "_tx"}, 64'(got_tx), 64'(exp_tx));
    check({tag, "_ocupado"}, 64'(got_oc), {24'd0, 40'hFF_FFFF_FFFF});
  endtask

  task automatic wait_idle(input int max, input string tag);
    int n = 0;
    while (ocupado && n < max) begin
      tick();
      n++;
    end
    check(tag, 64'(ocupado), 64'd0);
  endtask

  initial begin
    int n_low;

    // Reset state
    tick();
    tick();
    rst = 1'b0;
    check("rst_tx", 64'(tx), 64'd1);
    check("rst_ocupado", 64'(ocupado), 64'd0);
    check("rst_cheia", 64'(cheia), 64'd0);
    check("rst_desc", 64'(descartados), 64'd0);

    // Single byte: tx stays high at capture edge, falls one edge later
    stdout = 32'hDEADBE41;
    stdout_esc = 1'b1;
    tick();
    stdout_esc = 1'b0;
    check("single_lat_e0", 64'(tx), 64'd1);
    check("single_ocupado_e0", 64'(ocupado), 64'd1);
    tick();
    capture(8'h41, "single");
    check("single_ocupado_fall", 64'(ocupado), 64'd0);

    // Back-to-back strobes on consecutive cycles
    stdout = 32'h55;
    stdout_esc = 1'b1;
    tick();
    stdout = 32'hAA;
    tick();
    stdout = 32'h0F;
    capture(8'h55, "b2b_0");
    capture(8'hAA, "b2b_1");
    capture(8'h0F, "b2b_2");
    check("b2b_idle", 64'(ocupado), 64'd0);
    check("b2b_desc", 64'(descartados), 64'd0);

    // Overflow: six strobes, byte 1 popped immediately, byte 6 dropped
    rx_q.delete();
    for (int i = 1; i <= 6; i++) begin
      stdout = 32'(i);
      stdout_esc = 1'b1;
      tick();
      if (i == 4) check("ovf_cheia_4", 64'(cheia), 64'd0);
      if (i == 5) check("ovf_cheia_5", 64'(cheia), 64'd1);
    end
    stdout_esc = 1'b0;
    check("ovf_desc", 64'(descartados), 64'd1);
    for (int i = 0; i < 35; i++) tick();
    check("ovf_cheia_prepop", 64'(cheia), 64'd1);
    tick();
    check("ovf_cheia_postpop", 64'(cheia), 64'd0);
    wait_idle(1000, "ovf_drain");
    check("ovf_rx_count", 64'(rx_q.size()), 64'd5);
    for (int i = 0; i < 5; i++) check("ovf_rx_byte", 64'(rx_q[i]), 64'(i + 1));

    // Full FIFO with a strobe on the same edge as the stop-bit pop
    rx_q.delete();
    for (int i = 0; i < 5; i++) begin
      stdout = 32'hA0 + 32'(i);
      stdout_esc = 1'b1;
      tick();
    end
    stdout_esc = 1'b0;
    for (int i = 0; i < 36; i++) tick();
    check("simul_cheia_before", 64'(cheia), 64'd1);
    check("simul_tx_stop", 64'(tx), 64'd1);
    stdout = 32'h77;
    stdout_esc = 1'b1;
    tick();
    stdout_esc = 1'b0;
    check("simul_desc", 64'(descartados), 64'd2);
    check("simul_cheia_after", 64'(cheia), 64'd0);
    check("simul_next_start", 64'(tx), 64'd0);
    wait_idle(1000, "simul_drain");
    check("simul_rx_count", 64'(rx_q.size()), 64'd5);
    for (int i = 0; i < 5; i++) check("simul_rx_byte", 64'(rx_q[i]), 64'(8'hA0 + i));

    // Saturation of the drop counter
    for (int i = 0; i < 305; i++) begin
      stdout = 32'(i);
      stdout_esc = 1'b1;
      tick();
    end
    stdout_esc = 1'b0;
    check("sat_desc", 64'(descartados), 64'd255);
    wait_idle(1000, "sat_drain");
    check("sat_desc_hold", 64'(descartados), 64'd255);

    // Reset during the data bits with two bytes queued
    rx_q.delete();
    stdout = 32'h11;
    stdout_esc = 1'b1;
    tick();
    stdout = 32'h22;
    tick();
    stdout = 32'h33;
    tick();
    stdout_esc = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstmid_tx", 64'(tx), 64'd1);
    check("rstmid_ocupado", 64'(ocupado), 64'd0);
    check("rstmid_desc", 64'(descartados), 64'd0);
    check("rstmid_cheia", 64'(cheia), 64'd0);
    n_low = 0;
    for (int i = 0; i < 100; i++) begin
      if (tx == 1'b0) n_low++;
      tick();
    end
    check("rstmid_quiet", 64'(n_low), 64'd0);
    check("rstmid_rx_none", 64'(rx_q.size()), 64'd0);
    stdout = 32'h41;
    stdout_esc = 1'b1;
    tick();
    stdout_esc = 1'b0;
    check("rstmid_lat_e0", 64'(tx), 64'd1);
    tick();
    capture(8'h41, "rstmid_frame");
    check("rstmid_rx_count", 64'(rx_q.size()), 64'd1);
    check("rstmid_rx_byte", 64'(rx_q[0]), 64'h41);
    check("rx_framing", 64'(rx_bad), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
